pong_frame_renderer: RTL and testbench
======================================

// Module: pong_frame_renderer
// PURPOSE
//  Consumer end of the game-state interface: takes the next-state outputs of the
//  game core (ball/paddle positions, score, playfield dimensions) and turns them
//  into a row-major pixel stream for the display path.
//  On frame_start it snapshots the state, then scans every pixel under
//  valid/ready backpressure. Each pixel is classified background/ball/paddle/score.
// PARAMETERS
//  BALL_SIZE    4   ball square edge, pixels
//  PADDLE_W     4   paddle width, pixels
//  PADDLE_H     16  paddle height, pixels
//  SCORE_ROWS   4   rows at top of frame used for score bars
//  SCORE_SCALE  2   bar pixels per score point (power of 2)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  frame_start  in   1   request to render one frame from current inputs
//  dimensions   in   32  {width[31:16], height[15:0]}
//  ball_pos     in   32  ball top-left {x[31:16], y[15:0]}
//  lpaddle_pos  in   32  left paddle top-left {x[31:16], y[15:0]}
//  rpaddle_pos  in   32  right paddle top-left {x[31:16], y[15:0]}
//  score        in   16  {score_b[15:8], score_a[7:0]}
//  pix_valid    out  1   pixel on pix_* is valid
//  pix_ready    in   1   downstream accepts pixel
//  pix_code     out  2   0 bg, 1 ball, 2 paddle, 3 score
//  pix_sof      out  1   pixel is (0,0)
//  pix_eol      out  1   pixel is last of its row (x==width-1)
//  busy         out  1   high while in SCAN
//  frame_done   out  1   one-cycle pulse after last pixel accepted
//  frame_drop   out  1   one-cycle pulse: frame_start ignored (busy)
// BEHAVIOUR
//  - Reset: state IDLE, x=y=0, all outputs 0, snapshot registers 0.
//  - FSM IDLE: frame_start=1 at edge E -> capture all 5 state inputs; if width==0 or
//    height==0 pulse frame_done at E+1, stay IDLE; else go SCAN, x=y=0.
//  - SCAN: pix_valid=1 from the cycle after E; first pixel (0,0) with pix_sof=1.
//  - Handshake: advance only when pix_valid&&pix_ready; while stalled all pix_*
//    outputs hold stable. x increments; at x==width-1 wrap x=0, y++.
//  - Accepting (width-1,height-1): next cycle pix_valid=0, frame_done=1, busy=0,
//    state IDLE. frame_start in that frame_done cycle is accepted normally.
//  - frame_start while SCAN: ignored, frame_drop=1 next cycle; snapshot unchanged.
//  - Inputs may change freely during SCAN; only the snapshot is used.
//  - Classification (priority ball > paddle > score > bg), all compares in 17-bit
//    unsigned so box ends never wrap:
//    ball: bx<=x<bx+BALL_SIZE and by<=y<by+BALL_SIZE
//    paddle: same box test with PADDLE_W x PADDLE_H, for either paddle
//    score: y<SCORE_ROWS and (x<score_a*SCORE_SCALE or
//           x>=width-score_b*SCORE_SCALE, clamped at 0)
//  - Boxes partly/fully off-screen are clipped, never an error.
//  - pix_code/sof/eol registered; pixel output is a function of current (x,y).
//  - rst mid-frame: next cycle IDLE, pix_valid=0, no frame_done.
//  - Throughput: one pixel per cycle with pix_ready held high; no bubbles in a frame.
// TESTING
//  - rst, dims 8x4, pix_ready=1, frame_start 1 cycle -> 32 pixels, sof on 1st,
//    eol on x=7, frame_done 1 cycle after 32nd handshake.
//  - ball (2,1), paddles off-screen, score 0 -> code 1 exactly at x 2..5, y 1..3.
//  - ball (3,3) overlapping lpaddle (2,0) -> overlap pixels code 1, rest of paddle 2.
//  - dims 16x8, score {8'd2,8'd3} -> rows 0..3: x 0..5 code 3, x 12..15 code 3.
//  - Random pix_ready stalls -> pixel sequence identical to ready=1 run, outputs
//    stable during stall.
//  - frame_start mid-frame -> frame_drop pulse, frame unaffected; dims 0x5 ->
//    immediate frame_done, no pix_valid; rst mid-frame -> idle, no frame_done.

Source files
------------

// File: rtl/pong_frame_renderer_if.sv
// Pixel stream from the frame renderer to the display path, valid/ready handshake.
interface pong_frame_renderer_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [1:0] pix_code;
  logic       pix_sof;
  logic       pix_eol;

  modport master (output pix_valid, pix_code, pix_sof, pix_eol, input pix_ready);
  modport slave  (input pix_valid, pix_code, pix_sof, pix_eol, output pix_ready);
endinterface

// File: rtl/pong_frame_renderer.sv
// Snapshots the game state on frame_start and scans the playfield row-major,
// classifying each pixel as background, ball, paddle or score bar.
module pong_frame_renderer #(
  parameter int BALL_SIZE   = 4,
  parameter int PADDLE_W    = 4,
  parameter int PADDLE_H    = 16,
  parameter int SCORE_ROWS  = 4,
  parameter int SCORE_SCALE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start_i,
  input  logic [31:0]            dimensions_i,
  input  logic [31:0]            ball_pos_i,
  input  logic [31:0]            lpaddle_pos_i,
  input  logic [31:0]            rpaddle_pos_i,
  input  logic [15:0]            score_i,
  pong_frame_renderer_if.master  pix,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic                   frame_drop_o
);
  localparam logic [16:0] BS    = 17'(BALL_SIZE);
  localparam logic [16:0] PW    = 17'(PADDLE_W);
  localparam logic [16:0] PH    = 17'(PADDLE_H);
  localparam logic [16:0] SR    = 17'(SCORE_ROWS);
  localparam int          SC_SH = $clog2(SCORE_SCALE);

  typedef enum logic {IDLE, SCAN} state_e;

  typedef struct packed {
    logic [31:0] dims;
    logic [31:0] ball;
    logic [31:0] lpad;
    logic [31:0] rpad;
    logic [15:0] score;
  } snap_t;

  // 17-bit compares so bx+size never wraps past the 16-bit coordinate range
  function automatic logic in_box(input logic [15:0] px, input logic [15:0] py,
                                  input logic [31:0] pos, input logic [16:0] bw,
                                  input logic [16:0] bh);
    logic [16:0] x17, y17, bx, by;
    x17 = {1'b0, px};
    y17 = {1'b0, py};
    bx  = {1'b0, pos[31:16]};
    by  = {1'b0, pos[15:0]};
    return (x17 >= bx) && (x17 < bx + bw) && (y17 >= by) && (y17 < by + bh);
  endfunction

  function automatic logic [1:0] classify(input logic [15:0] px, input logic [15:0] py,
                                          input snap_t s);
    logic [16:0] w17, a_end, b_len, b_start;
    logic [1:0]  c;
    w17     = {1'b0, s.dims[31:16]};
    a_end   = {9'd0, s.score[7:0]} << SC_SH;
    b_len   = {9'd0, s.score[15:8]} << SC_SH;
    b_start = (b_len >= w17) ? 17'd0 : w17 - b_len;
    if (in_box(px, py, s.ball, BS, BS))
      c = 2'd1;
    else if (in_box(px, py, s.lpad, PW, PH) || in_box(px, py, s.rpad, PW, PH))
      c = 2'd2;
    else if (({1'b0, py} < SR) && (({1'b0, px} < a_end) || ({1'b0, px} >= b_start)))
      c = 2'd3;
    else
      c = 2'd0;
    return c;
  endfunction

  state_e      state_q, state_d;
  snap_t       snap_q, snap_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic [1:0]  code_q, code_d;
  logic        done_q, done_d, drop_q, drop_d;
  logic        load;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    code_d  = code_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: if (frame_start_i) begin
        snap_d = '{dimensions_i, ball_pos_i, lpaddle_pos_i, rpaddle_pos_i, score_i};
        if (dimensions_i[31:16] == 16'd0 || dimensions_i[15:0] == 16'd0) begin
          done_d = 1'b1;
        end else begin
          state_d = SCAN;
          x_d     = 16'd0;
          y_d     = 16'd0;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      SCAN: begin
        drop_d = frame_start_i;
        if (valid_q && pix.pix_ready) begin
          if (x_q == snap_q.dims[31:16] - 16'd1) begin
            if (y_q == snap_q.dims[15:0] - 16'd1) begin
              state_d = IDLE;
              valid_d = 1'b0;
              done_d  = 1'b1;
              code_d  = 2'd0;
              sof_d   = 1'b0;
              eol_d   = 1'b0;
            end else begin
              x_d  = 16'd0;
              y_d  = y_q + 16'd1;
              load = 1'b1;
            end
          end else begin
            x_d  = x_q + 16'd1;
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // pixel outputs are precomputed for the coordinate about to be presented
    if (load) begin
      code_d = classify(x_d, y_d, snap_d);
      sof_d  = (x_d == 16'd0) && (y_d == 16'd0);
      eol_d  = (x_d == snap_d.dims[31:16] - 16'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign pix.pix_valid = valid_q;
  assign pix.pix_code  = code_q;
  assign pix.pix_sof   = sof_q;
  assign pix.pix_eol   = eol_q;
  assign busy_o        = (state_q == SCAN);
  assign frame_done_o  = done_q;
  assign frame_drop_o  = drop_q;
endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for the pong frame renderer: frame shape, classification,
// backpressure, dropped starts, empty frames and mid-frame reset.
module tb_pong_frame_renderer;
  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [31:0] dimensions, ball_pos, lpaddle_pos, rpaddle_pos;
  logic [15:0] score;
  logic        busy, frame_done, frame_drop;

  pong_frame_renderer_if pif();

  pong_frame_renderer dut (
    .clk(clk), .rst(rst), .frame_start_i(frame_start), .dimensions_i(dimensions),
    .ball_pos_i(ball_pos), .lpaddle_pos_i(lpaddle_pos), .rpaddle_pos_i(rpaddle_pos),
    .score_i(score), .pix(pif.master), .busy_o(busy), .frame_done_o(frame_done),
    .frame_drop_o(frame_drop)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  logic [1:0] cap_code [0:255];
  logic       cap_sof  [0:255];
  logic       cap_eol  [0:255];
  logic [1:0] exp_code [0:255];
  int         ncap, last_acc, done_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Must be called at a negedge; frame_start is seen by the next posedge.
  task automatic start_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Runs from the current negedge until frame_done, recording accepted pixels.
  task automatic collect(input string tag, input bit rnd, input int inj_at);
    int        cyc = 0;
    bit        held = 0;
    bit        got_done = 0;
    logic [4:0] hv = '0;
    ncap = 0; last_acc = -1; done_cyc = -1;
    while (cyc < 2000 && !got_done) begin
      if (held)
        chk({tag, " stall_hold"}, {27'd0, pif.pix_valid, pif.pix_code, pif.pix_sof, pif.pix_eol}, {27'd0, hv});
      if (inj_at >= 0 && cyc == inj_at) begin
        frame_start = 1'b1;
        ball_pos    = 32'h0000_0000;
        dimensions  = 32'h0002_0002;
      end
      if (inj_at >= 0 && cyc == inj_at + 1) begin
        frame_start = 1'b0;
        chk({tag, " frame_drop"}, {31'd0, frame_drop}, 32'd1);
      end
      if (inj_at >= 0 && cyc == inj_at + 2)
        chk({tag, " frame_drop_end"}, {31'd0, frame_drop}, 32'd0);
      if (frame_done) begin
        done_cyc = cyc;
        got_done = 1;
      end else begin
        pif.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pif.pix_valid && pif.pix_ready && ncap < 256) begin
          cap_code[ncap] = pif.pix_code;
          cap_sof[ncap]  = pif.pix_sof;
          cap_eol[ncap]  = pif.pix_eol;
          ncap++;
          last_acc = cyc;
        end
        held = pif.pix_valid && !pif.pix_ready;
        hv   = {pif.pix_valid, pif.pix_code, pif.pix_sof, pif.pix_eol};
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, " frame_done_seen"}, {31'd0, got_done}, 32'd1);
    chk({tag, " done_latency"}, done_cyc, last_acc + 1);
    chk({tag, " valid_at_done"}, {31'd0, pif.pix_valid}, 32'd0);
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic compare_frame(input string tag, input int w, input int h);
    chk({tag, " pixel_count"}, ncap, w * h);
    for (int i = 0; i < w * h && i < ncap; i++) begin
      chk($sformatf("%s code[%0d,%0d]", tag, i % w, i / w), {30'd0, cap_code[i]}, {30'd0, exp_code[i]});
      chk($sformatf("%s sof[%0d]", tag, i), {31'd0, cap_sof[i]}, {31'd0, (i == 0)});
      chk($sformatf("%s eol[%0d]", tag, i), {31'd0, cap_eol[i]}, {31'd0, (i % w == w - 1)});
    end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; pif.pix_ready = 1'b1;
    dimensions = '0; ball_pos = '0; lpaddle_pos = '0; rpaddle_pos = '0; score = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst pix_valid", {31'd0, pif.pix_valid}, 32'd0);
    chk("rst pix_code", {30'd0, pif.pix_code}, 32'd0);
    chk("rst pix_sof", {31'd0, pif.pix_sof}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst frame_drop", {31'd0, frame_drop}, 32'd0);

    // 8x4 frame, ball at (2,1), paddles off-screen, no score
    dimensions = {16'd8, 16'd4}; ball_pos = {16'd2, 16'd1};
    lpaddle_pos = {16'd100, 16'd100}; rpaddle_pos = {16'd200, 16'd0}; score = 16'd0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        exp_code[y * 8 + x] = (x >= 2 && x <= 5 && y >= 1) ? 2'd1 : 2'd0;
    start_frame();
    chk("A first valid", {31'd0, pif.pix_valid}, 32'd1);
    chk("A first sof", {31'd0, pif.pix_sof}, 32'd1);
    chk("A busy", {31'd0, busy}, 32'd1);
    collect("A", 1'b0, -1);
    compare_frame("A", 8, 4);
    @(negedge clk);
    chk("A done_pulse_end", {31'd0, frame_done}, 32'd0);
    chk("A idle_valid", {31'd0, pif.pix_valid}, 32'd0);

    // same frame, with a dropped frame_start and input changes mid-scan
    start_frame();
    collect("DROP", 1'b0, 5);
    compare_frame("DROP", 8, 4);

    // back-to-back start in the frame_done cycle: ball (3,3) over lpaddle (2,0)
    dimensions = {16'd8, 16'd4}; ball_pos = {16'd3, 16'd3};
    lpaddle_pos = {16'd2, 16'd0}; rpaddle_pos = {16'd100, 16'd100}; score = 16'd0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        exp_code[y * 8 + x] = (x >= 3 && x <= 6 && y == 3) ? 2'd1 :
                              (x >= 2 && x <= 5) ? 2'd2 : 2'd0;
    start_frame();
    chk("OVL b2b valid", {31'd0, pif.pix_valid}, 32'd1);
    collect("OVL", 1'b0, -1);
    compare_frame("OVL", 8, 4);
    @(negedge clk);

    // 16x8 with score a=3, b=2; rpaddle (14,2) beats score in rows 2..3
    dimensions = {16'd16, 16'd8}; ball_pos = {16'd100, 16'd100};
    lpaddle_pos = {16'd300, 16'd0}; rpaddle_pos = {16'd14, 16'd2}; score = {8'd2, 8'd3};
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++)
        exp_code[y * 16 + x] = (x >= 14 && y >= 2) ? 2'd2 :
                               (y < 4 && (x < 6 || x >= 12)) ? 2'd3 : 2'd0;
    start_frame();
    collect("SCORE", 1'b0, -1);
    compare_frame("SCORE", 16, 8);
    @(negedge clk);

    // same frame under random backpressure
    start_frame();
    collect("STALL", 1'b1, -1);
    compare_frame("STALL", 16, 8);
    pif.pix_ready = 1'b1;
    @(negedge clk);

    // zero-width frame: immediate done, no pixels
    dimensions = {16'd0, 16'd5};
    start_frame();
    chk("ZERO frame_done", {31'd0, frame_done}, 32'd1);
    chk("ZERO pix_valid", {31'd0, pif.pix_valid}, 32'd0);
    chk("ZERO busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("ZERO done_end", {31'd0, frame_done}, 32'd0);
    chk("ZERO valid_after", {31'd0, pif.pix_valid}, 32'd0);

    // reset mid-frame
    dimensions = {16'd8, 16'd4};
    start_frame();
    repeat (6) @(negedge clk);
    chk("RST mid busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("RST pix_valid", {31'd0, pif.pix_valid}, 32'd0);
    chk("RST busy", {31'd0, busy}, 32'd0);
    chk("RST frame_done", {31'd0, frame_done}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done || pif.pix_valid)
        chk($sformatf("RST quiet[%0d]", i), {30'd0, frame_done, pif.pix_valid}, 32'd0);
    end
    chk("RST quiet_end", {30'd0, frame_done, pif.pix_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
